// File: rtl/scan_sequencer.sv
// Autonomous scan-chain sequencer: shifts {index, din} MSB first onto tdi under a divided tck and captures tdo into dout.
// Optional adaptive clocking on returned rtck with timeout is enabled by defining SCAN_RTCK_EN.
module scan_sequencer #(
    parameter int DIV     = 3,
    parameter int IDX_W   = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] din,
    input  logic              tdo,
    input  logic              rtck,
    output logic              tck,
    output logic              tdi,
    output logic              tms,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              err
);
    localparam int N     = IDX_W + DATA_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam int DIV_W = $clog2(DIV + 1);

    // state    | meaning
    // IDLE     | waiting for start
    // SHIFT_LO | tck low, tdi = current bit, tdo sampled on last cycle
    // SHIFT_HI | tck high, advance to next bit on exit
    // UPD_LO   | update pulse low half, tms = 0
    // UPD_HI   | update pulse high half
    // DONE     | one-cycle done pulse, dout loaded; accepts start
    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_UPD_LO, S_UPD_HI, S_DONE
    } state_t;

    state_t             state;
    logic [N-1:0]       shreg;
    logic [DATA_W-1:0]  cap;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               phase_end;
    logic               phase_timeout;

`ifdef SCAN_RTCK_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [1:0]       rtck_sync;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtck_sync <= '0;
            tmo_cnt   <= TMO_W'(TIMEOUT - 1);
        end else begin
            rtck_sync <= {rtck_sync[0], rtck};
            if (!busy || phase_end)
                tmo_cnt <= TMO_W'(TIMEOUT - 1);
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign phase_end     = (div_cnt == '0) && (rtck_sync[1] == tck);
    assign phase_timeout = busy && (tmo_cnt == '0) && !phase_end;
`else
    logic unused_rtck_cfg;
    assign unused_rtck_cfg = rtck ^ (TIMEOUT == 0);
    assign phase_end       = (div_cnt == '0);
    assign phase_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cap     <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            tck     <= 1'b0;
            tdi     <= 1'b0;
            tms     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (phase_timeout) begin
                err   <= 1'b1;
                tck   <= 1'b0;
                tms   <= 1'b0;
                tdi   <= 1'b0;
                busy  <= 1'b0;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (start) begin
                            shreg   <= {index, din};
                            cap     <= '0;
                            bit_cnt <= CNT_W'(N);
                            div_cnt <= DIV_W'(DIV - 1);
                            busy    <= 1'b1;
                            tck     <= 1'b0;
                            tms     <= 1'b1;
                            tdi     <= index[IDX_W-1];
                            state   <= S_SHIFT_LO;
                        end
                    end
                    S_SHIFT_LO: begin
                        if (phase_end) begin
                            cap     <= {cap[DATA_W-2:0], tdo};
                            tck     <= 1'b1;
                            div_cnt <= DIV_W'(DIV - 1);
                            state   <= S_SHIFT_HI;
                        end else if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    S_SHIFT_HI: begin
                        if (phase_end) begin
                            shreg   <= {shreg[N-2:0], 1'b0};
                            bit_cnt <= bit_cnt - 1'b1;
                            tck     <= 1'b0;
                            div_cnt <= DIV_W'(DIV - 1);
                            if (bit_cnt == CNT_W'(1)) begin
                                tms   <= 1'b0;
                                tdi   <= 1'b0;
                                state <= S_UPD_LO;
                            end else begin
                                tdi   <= shreg[N-2];
                                state <= S_SHIFT_LO;
                            end
                        end else if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    S_UPD_LO: begin
                        if (phase_end) begin
                            tck     <= 1'b1;
                            div_cnt <= DIV_W'(DIV - 1);
                            state   <= S_UPD_HI;
                        end else if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    S_UPD_HI: begin
                        if (phase_end) begin
                            tck   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            dout  <= cap;
                            state <= S_DONE;
                        end else if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer (default build, DIV=2, 8+8 bit frames) against a frame-level reference model.
module tb_scan_sequencer;
    localparam int DIV = 2;
    localparam int N   = 16;
    localparam int LAT = 1 + (N + 1) * 2 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] index = '0;
    logic [7:0] din = '0;
    logic       tdo;
    logic       rtck = 1'b0;
    logic       tck, tdi, tms, busy, done, err;
    logic [7:0] dout;

    int tests = 0;
    int fails = 0;

    // chain model: pattern mode returns pat bit k during bit k; loopback mode returns tdi delayed 8 tck
    logic        tdo_mode = 1'b0;
    logic [15:0] pat = '0;
    int          rise_cnt = 0;
    int          rise_base = 0;
    int          q_base = 0;
    logic [7:0]  lb = '0;
    logic [1:0]  rise_q[$];

    always #5 clk = ~clk;

    always @(posedge tck) begin
        rise_q.push_back({tms, tdi});
        rise_cnt = rise_cnt + 1;
        lb = {lb[6:0], tdi};
    end

    function automatic logic pat_bit(input int rc, input int rb, input logic [15:0] p);
        int k;
        k = rc - rb;
        if (k >= 0 && k < N) return p[N-1-k];
        return 1'b0;
    endfunction

    assign tdo = tdo_mode ? lb[7] : pat_bit(rise_cnt, rise_base, pat);

    scan_sequencer #(.DIV(DIV), .IDX_W(8), .DATA_W(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .index(index), .din(din),
        .tdo(tdo), .rtck(rtck), .tck(tck), .tdi(tdi), .tms(tms),
        .busy(busy), .done(done), .dout(dout), .err(err)
    );

    // number of tck rises since base whose {tms,tdi} differ from the expected frame, plus count error
    function automatic int stream_errs(input logic [15:0] bits, input int base);
        int e;
        logic [1:0] exp_v;
        e = 0;
        if (rise_q.size() - base != N + 1) e++;
        for (int k = 0; k <= N; k++) begin
            exp_v = (k < N) ? {1'b1, bits[N-1-k]} : 2'b00;
            if (base + k >= rise_q.size()) e++;
            else if (rise_q[base + k] !== exp_v) e++;
        end
        return e;
    endfunction

    task automatic drive_frame(input logic [7:0] idx, input logic [7:0] d, input bit noise,
                               output int done_at, output int busy_n, output int err_n);
        @(negedge clk);
        index = idx;
        din = d;
        start = 1'b1;
        rise_base = rise_cnt;
        q_base = rise_q.size();
        @(posedge clk);
        #1;
        start = 1'b0;
        done_at = -1;
        busy_n = 0;
        err_n = 0;
        for (int c = 1; c <= LAT + 20; c++) begin
            if (busy === 1'b1) busy_n++;
            if (err !== 1'b0) err_n++;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            if (noise && c < LAT - 8) begin
                start = ($urandom_range(0, 2) == 0);
                index = 8'($urandom);
                din = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({tck, tdi, tms, busy, done, err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000", {tck, tdi, tms, busy, done, err});
        end
        tests++;
        if (dout !== 8'h00) begin
            fails++;
            $display("FAIL reset_dout: got %h expected 00", dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || tck !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b tck=%b expected 0 0", busy, tck);
        end
    endtask

    task automatic test_spec_frame();
        int d_at, b_n, e_n, se;
        tdo_mode = 1'b1;
        drive_frame(8'h02, 8'hA5, 1'b0, d_at, b_n, e_n);
        se = stream_errs(16'h02A5, q_base);
        tests++;
        if (d_at != LAT) begin
            fails++;
            $display("FAIL spec_latency: done at cycle %0d expected %0d", d_at, LAT);
        end
        tests++;
        if (b_n != LAT - 1) begin
            fails++;
            $display("FAIL spec_busy: busy cycles %0d expected %0d", b_n, LAT - 1);
        end
        tests++;
        if (se != 0) begin
            fails++;
            $display("FAIL spec_stream: %0d bad tck rises, got %0d rises expected 17", se, rise_q.size() - q_base);
        end
        tests++;
        if (dout !== 8'h02 || busy !== 1'b0) begin
            fails++;
            $display("FAIL spec_dout: dout=%h busy=%b expected 02 0", dout, busy);
        end
        tests++;
        if (e_n != 0) begin
            fails++;
            $display("FAIL spec_err: err high %0d cycles expected 0", e_n);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL spec_done_width: done=%b expected 0", done);
        end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (dout !== 8'h02) begin
            fails++;
            $display("FAIL spec_dout_hold: dout=%h expected 02", dout);
        end
    endtask

    task automatic test_tdo_tied();
        int d_at, b_n, e_n;
        tdo_mode = 1'b0;
        pat = 16'hFFFF;
        drive_frame(8'($urandom), 8'($urandom), 1'b0, d_at, b_n, e_n);
        tests++;
        if (d_at != LAT || dout !== 8'hFF) begin
            fails++;
            $display("FAIL tdo_tied: done at %0d dout=%h expected %0d FF", d_at, dout, LAT);
        end
    endtask

    task automatic test_random();
        int d_at, b_n, e_n, se;
        logic [7:0] idx, d;
        tdo_mode = 1'b0;
        for (int f = 0; f < 6; f++) begin
            idx = 8'($urandom);
            d = 8'($urandom);
            pat = 16'($urandom);
            drive_frame(idx, d, 1'b0, d_at, b_n, e_n);
            se = stream_errs({idx, d}, q_base);
            tests++;
            if (dout !== pat[7:0]) begin
                fails++;
                $display("FAIL rand_dout[%0d]: got %h expected %h", f, dout, pat[7:0]);
            end
            tests++;
            if (se != 0) begin
                fails++;
                $display("FAIL rand_stream[%0d]: %0d bad rises for frame %h", f, se, {idx, d});
            end
            tests++;
            if (d_at != LAT || b_n != LAT - 1) begin
                fails++;
                $display("FAIL rand_timing[%0d]: done %0d busy %0d expected %0d %0d", f, d_at, b_n, LAT, LAT - 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int d_at, b_n, e_n, se, extra;
        tdo_mode = 1'b1;
        drive_frame(8'h5C, 8'h3E, 1'b1, d_at, b_n, e_n);
        se = stream_errs(16'h5C3E, q_base);
        tests++;
        if (d_at != LAT || se != 0) begin
            fails++;
            $display("FAIL ignore_frame: done %0d bad rises %0d expected %0d 0", d_at, se, LAT);
        end
        tests++;
        if (dout !== 8'h5C) begin
            fails++;
            $display("FAIL ignore_dout: got %h expected 5C", dout);
        end
        extra = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignore_single_done: %0d extra busy/done cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, c;
        logic busy_after;
        logic [7:0] dout1;
        tdo_mode = 1'b1;
        c1 = -1;
        c2 = -1;
        busy_after = 1'b0;
        dout1 = '0;
        @(negedge clk);
        index = 8'h9B;
        din = 8'h17;
        start = 1'b1;
        @(posedge clk);
        #1;
        c = 1;
        while (c < 3 * LAT && c2 < 0) begin
            if (done === 1'b1 && c1 < 0) begin
                c1 = c;
                dout1 = dout;
                index = 8'h64;
                din = 8'hC8;
            end else if (done === 1'b1) begin
                c2 = c;
            end
            if (c1 > 0 && c == c1 + 1) begin
                busy_after = busy;
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        tests++;
        if (c1 != LAT || dout1 !== 8'h9B) begin
            fails++;
            $display("FAIL b2b_first: done %0d dout %h expected %0d 9B", c1, dout1, LAT);
        end
        tests++;
        if (busy_after !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap: busy after done=%b expected 1", busy_after);
        end
        tests++;
        if (c2 != 2 * LAT || dout !== 8'h64) begin
            fails++;
            $display("FAIL b2b_second: done %0d dout %h expected %0d 64", c2, dout, 2 * LAT);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int d_at, b_n, e_n, se;
        tdo_mode = 1'b0;
        pat = 16'h1234;
        @(negedge clk);
        index = 8'hF0;
        din = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({tck, tms, busy} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_ctrl: tck/tms/busy=%b expected 000", {tck, tms, busy});
        end
        tests++;
        if (dout !== 8'h00) begin
            fails++;
            $display("FAIL midreset_dout: got %h expected 00", dout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pat = 16'hBEEF;
        drive_frame(8'hC3, 8'h81, 1'b0, d_at, b_n, e_n);
        se = stream_errs(16'hC381, q_base);
        tests++;
        if (d_at != LAT || se != 0 || dout !== 8'hEF) begin
            fails++;
            $display("FAIL midreset_clean: done %0d bad rises %0d dout %h expected %0d 0 EF", d_at, se, dout, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_tdo_tied();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
